// File: rtl/flash_access_arbiter.sv
`default_nettype none
// flash_access_arbiter: round-robin sharing of one flash controller between two read ports,
// one outstanding read, bounded wait with timeout abort.  Rev 1.0
module flash_access_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              valid0,
  output logic              valid1,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout_err,
  output logic              busy,
  output logic              fmc_req,
  output logic [ADDR_W-1:0] fmc_addr,
  input  logic              fmc_ready,
  input  logic [DATA_W-1:0] fmc_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner;   // 0: port 0 holds the fmc, 1: port 1
  logic       pref;    // port that wins a simultaneous request
  logic [7:0] cnt;
  logic       pick;

  // Single requester wins outright; on a tie the round-robin pointer decides.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = pref;
    else if (req1)    pick = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      pref        <= 1'b0;
      cnt         <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
      rdata       <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      fmc_req     <= 1'b0;
      fmc_addr    <= '0;
    end else begin
      fmc_req     <= 1'b0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            fmc_addr <= pick ? addr1 : addr0;
            gnt0     <= ~pick;
            gnt1     <= pick;
            busy     <= 1'b1;
            fmc_req  <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A ready arriving on the last allowed cycle still counts as success.
          if (fmc_ready) begin
            rdata  <= fmc_data;
            valid0 <= ~owner;
            valid1 <= owner;
            state  <= S_DONE;
          end else if (cnt == TO_LAST) begin
            rdata       <= '0;
            valid0      <= ~owner;
            valid1      <= owner;
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          pref  <= ~owner;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
